// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/execute/update control with fetch timeout and retire count
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic        add_sel,
    output logic [25:0] jaddr,
    output logic [15:0] imm,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] new_pc,
    output logic        fault,
    output logic [31:0] retired
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, HALT} state_t;
    state_t      state;
    logic [31:0] wait_cnt;
    logic        decoding, is_jump, is_bne, is_jr;

    assign imem_addr = pc;
    assign jaddr     = instr[25:0];
    assign imm       = instr[15:0];
    assign decoding  = state == EXEC || state == UPDATE;
    assign is_jump   = instr[31:26] == 6'b000010 || instr[31:26] == 6'b000011;
    assign is_bne    = instr[31:26] == 6'b000101;
    assign is_jr     = instr[31:26] == 6'b000000 && instr[5:0] == 6'b001000;
    assign pc_sel    = !decoding ? 2'd1 : is_jump ? 2'd0 : is_jr ? 2'd2 : 2'd1;
    assign add_sel   = decoding && is_bne;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            retired     <= '0;
            wait_cnt    <= '0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                end
                // an ack arriving on the final allowed cycle still wins over the timeout
                FETCH: if (imem_ack) begin
                    instr       <= imem_rdata;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b1;
                    state       <= EXEC;
                end else if (wait_cnt == 32'(FETCH_TIMEOUT)) begin
                    fault    <= 1'b1;
                    imem_req <= 1'b0;
                    state    <= HALT;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
                EXEC: if (exec_done) state <= UPDATE;
                UPDATE: begin
                    pc       <= new_pc;
                    retired  <= retired + 32'd1;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                    state    <= FETCH;
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus randomized checks against a per-instruction reference model
module tb_fetch_sequencer;
    localparam int FT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0, add_sel, instr_valid, exec_done = 1'b0, fault;
    logic [31:0] imem_addr, imem_rdata = '0, pc, instr, new_pc = '0, retired;
    logic [1:0]  pc_sel;
    logic [25:0] jaddr;
    logic [15:0] imm;

    int          checks = 0, errors = 0;
    logic [31:0] mpc, mret;

    fetch_sequencer #(.RESET_PC(32'h0), .FETCH_TIMEOUT(FT)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc_sel(pc_sel),
        .add_sel(add_sel), .jaddr(jaddr), .imm(imm), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .new_pc(new_pc),
        .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // expected {pc_sel, add_sel} for an instruction word, from the opcode table
    function automatic logic [2:0] dec(input logic [31:0] w);
        int op = int'(w >> 26);
        int fn = int'(w & 32'h3F);
        if (op == 2 || op == 3) return 3'b000;
        if (op == 5) return 3'b011;
        if (op == 0 && fn == 8) return 3'b100;
        return 3'b010;
    endfunction

    task automatic chk_idle_ctl(input string tag);
        chk({tag, "_pcsel"}, 32'(pc_sel), 32'd1);
        chk({tag, "_addsel"}, 32'(add_sel), 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        chk("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        mpc = 32'h0;
        mret = 32'h0;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, 32'h0);
    endtask

    // Called at a negedge in FETCH; returns at the negedge after UPDATE (back in FETCH).
    task automatic run_instr(input logic [31:0] w, input int d, input int ew,
                             input logic [31:0] np, input bit wrap);
        logic [2:0] e = dec(w);
        for (int i = 0; i <= d; i++) begin
            chk("f_req", 32'(imem_req), 32'd1);
            chk("f_addr", imem_addr, mpc);
            chk("f_valid", 32'(instr_valid), 32'd0);
            chk_idle_ctl("f");
            imem_ack = (i == d);
            imem_rdata = (i == d) ? w : $urandom;
            exec_done = (i == d) ? 1'b0 : 1'($urandom);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        chk("e_valid", 32'(instr_valid), 32'd1);
        chk("e_instr", instr, w);
        chk("e_jaddr", 32'(jaddr), 32'(w[25:0]));
        chk("e_imm", 32'(imm), 32'(w[15:0]));
        chk("e_pcsel", 32'(pc_sel), 32'(e[2:1]));
        chk("e_addsel", 32'(add_sel), 32'(e[0]));
        chk("e_req", 32'(imem_req), 32'd0);
        if (wrap) begin
            force dut.retired = 32'hFFFF_FFFF;
            #1 release dut.retired;
            mret = 32'hFFFF_FFFF;
            chk("preload", retired, mret);
        end
        for (int i = 0; i < ew; i++) begin
            imem_ack = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
            chk("w_valid", 32'(instr_valid), 32'd0);
            chk("w_instr", instr, w);
            chk("w_pcsel", 32'(pc_sel), 32'(e[2:1]));
        end
        imem_ack = 1'b0;
        exec_done = 1'b1;
        new_pc = np;
        @(negedge clk);
        exec_done = 1'b0;
        chk("u_pcsel", 32'(pc_sel), 32'(e[2:1]));
        chk("u_addsel", 32'(add_sel), 32'(e[0]));
        chk("u_pc", pc, mpc);
        @(negedge clk);
        mpc = np;
        mret = mret + 32'd1;
        chk("n_pc", pc, mpc);
        chk("n_retired", retired, mret);
        chk("n_req", 32'(imem_req), 32'd1);
        chk("n_addr", imem_addr, mpc);
    endtask

    initial begin
        logic [31:0] w;
        #1;
        chk("por_req", 32'(imem_req), 32'd0);
        chk("por_pc", pc, 32'h0);
        reset_dut();

        // minimal-latency sequential instruction, then reset while in EXEC
        run_instr(32'h2002_0005, 0, 0, 32'h4, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0800_0010;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        reset_dut();

        run_instr(32'h0800_0010, 2, 1, 32'h40, 1'b0);
        run_instr(32'h1422_0003, 0, 2, 32'h50, 1'b0);
        run_instr(32'h03E0_0008, 1, 0, 32'h80, 1'b0);
        run_instr(32'h0C00_0123, 0, 0, 32'h48c, 1'b0);
        run_instr(32'h2002_0005, 10, 3, 32'h490, 1'b0);

        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            case ($urandom_range(0, 4))
                0: w = {6'b000010 | 6'(w[0]), w[25:0]};
                1: w = {6'b000101, w[25:0]};
                2: w = {6'b000000, w[25:6], 6'b001000};
                3: w = {6'b000000, w[25:0]};
                default: ;
            endcase
            run_instr(w, $urandom_range(0, 12), $urandom_range(0, 3), $urandom, 1'b0);
        end

        // retire counter wraps, then ack on the last allowed fetch cycle is accepted
        run_instr(32'h2002_0005, 0, 1, 32'h100, 1'b1);
        chk("wrap_zero", retired, 32'h0);
        run_instr(32'h2002_0005, FT, 0, 32'h104, 1'b0);
        chk("edge_fault", 32'(fault), 32'd0);

        // no ack: fault after the full wait, then frozen
        for (int i = 0; i <= FT; i++) begin
            chk("t_req", 32'(imem_req), 32'd1);
            chk("t_fault", 32'(fault), 32'd0);
            @(negedge clk);
        end
        chk("halt_fault", 32'(fault), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            exec_done = 1'b1;
            new_pc = $urandom;
            @(negedge clk);
            chk("halt_pc", pc, mpc);
            chk("halt_retired", retired, mret);
            chk("halt_req2", 32'(imem_req), 32'd0);
            chk("halt_fault2", 32'(fault), 32'd1);
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        reset_dut();

        // reset mid-FETCH with an ack in flight: the ack must be lost
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        #1;
        chk("mf_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mf_instr", instr, 32'h0);
        chk("mf_req2", 32'(imem_req), 32'd1);
        chk("mf_valid", 32'(instr_valid), 32'd0);
        mpc = 32'h0;
        mret = 32'h0;
        run_instr(32'h1422_FFFF, 3, 1, 32'h8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
